// File: rtl/vote_pkg.sv
// Shared definitions for the voting-machine LED display controller.
//   state_t    : controller FSM states
//   LED_ALL_ON : all-ones acknowledge pattern, truncated to LED_W by users
//   fit()      : resize a tally onto the LED bus, saturating when it does not fit
// fit() works on FIT_W-bit values, so VOTE_W and LED_W must both be <= FIT_W.
package vote_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_RESULT} state_t;

  localparam int FIT_W = 32;
  localparam logic [FIT_W-1:0] LED_ALL_ON = '1;

  // Zero-extend if the value fits in led_w bits, else saturate to led_w ones.
  function automatic logic [FIT_W-1:0] fit(input logic [FIT_W-1:0] v, input int led_w);
    logic [FIT_W-1:0] lo_mask;
    if (led_w >= FIT_W) return v;
    lo_mask = (FIT_W'(1) << led_w) - FIT_W'(1);
    return ((v & ~lo_mask) != '0) ? lo_mask : v;
  endfunction

endpackage

// File: rtl/vote_leader_find.sv
// Combinational NUM_CAND-way maximum over the candidate tallies.
//   tally    in   packed tallies, candidate i at tally[i]
//   lead_idx out  index of the largest tally; ties go to the lower index
module vote_leader_find #(
  parameter int NUM_CAND = 4,
  parameter int VOTE_W   = 8,
  parameter int IDX_W    = 2
) (
  input  logic [NUM_CAND-1:0][VOTE_W-1:0] tally,
  output logic [IDX_W-1:0]                lead_idx
);

  logic [VOTE_W-1:0] best;

  // Strict '>' keeps the earlier (lower) index on a tie.
  always_comb begin
    best     = tally[0];
    lead_idx = '0;
    for (int i = 1; i < NUM_CAND; i++) begin
      if (tally[i] > best) begin
        best     = tally[i];
        lead_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/vote_display_ctrl.sv
// LED display controller for the voting machine, NUM_CAND candidates.
// Voting mode flashes all LEDs for HOLD_CYCLES cycles after the last vote;
// result mode shows the (saturated) tally of the selected candidate.
//   clock              in   system clock, rising edge
//   reset_n            in   async active-low reset (release synchronised internally)
//   mode               in   0 = voting, 1 = result
//   valid_vote_casted  in   1-cycle pulse per accepted vote
//   cand_votes         in   packed tallies, candidate i at [i*VOTE_W +: VOTE_W]
//   cand_button        in   candidate select buttons, level
//   leds               out  registered LED pattern
//   ack_busy           out  high while the acknowledge pattern is shown
//   sel_idx            out  latched selected candidate
// Optional feature macro: LEADER_DISPLAY_EN -- on entering result mode the
// display follows the current leader until the first button press.
// VOTE_W and LED_W must be <= 32.
module vote_display_ctrl
  import vote_pkg::*;
#(
  parameter int NUM_CAND    = 4,
  parameter int VOTE_W      = 8,
  parameter int LED_W       = 8,
  parameter int HOLD_CYCLES = 10
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         mode,
  input  logic                         valid_vote_casted,
  input  logic [NUM_CAND*VOTE_W-1:0]   cand_votes,
  input  logic [NUM_CAND-1:0]          cand_button,
  output logic [LED_W-1:0]             leds,
  output logic                         ack_busy,
  output logic [$clog2(NUM_CAND)-1:0]  sel_idx
);

  localparam int IDX_W  = $clog2(NUM_CAND);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

  // Assert asynchronously, release two clocks later on a clean edge.
  logic [1:0] rst_sync;
  logic       rst_n_int;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_int = rst_sync[1];

  logic [NUM_CAND-1:0][VOTE_W-1:0] tally;
  assign tally = cand_votes;

  state_t            state, state_d;
  logic [HOLD_W-1:0] hold_cnt, hold_d;
  logic [IDX_W-1:0]  sel_d;
  logic [LED_W-1:0]  leds_d;

  // Lowest pressed button wins.
  logic             btn_any;
  logic [IDX_W-1:0] btn_idx;

  always_comb begin
    btn_any = |cand_button;
    btn_idx = '0;
    for (int i = NUM_CAND - 1; i >= 0; i--)
      if (cand_button[i]) btn_idx = IDX_W'(i);
  end

`ifdef LEADER_DISPLAY_EN
  logic [IDX_W-1:0] lead_idx;
  logic             manual, manual_d;

  vote_leader_find #(
    .NUM_CAND (NUM_CAND),
    .VOTE_W   (VOTE_W),
    .IDX_W    (IDX_W)
  ) u_leader (
    .tally    (tally),
    .lead_idx (lead_idx)
  );
`endif

  always_comb begin
    state_d = state;
    hold_d  = hold_cnt;
    sel_d   = sel_idx;
`ifdef LEADER_DISPLAY_EN
    manual_d = manual;
`endif
    case (state)
      S_IDLE: begin
        // Mode has priority over a same-cycle vote pulse.
        if (mode) begin
          state_d = S_RESULT;
`ifdef LEADER_DISPLAY_EN
          sel_d    = lead_idx;
          manual_d = 1'b0;
`endif
        end else if (valid_vote_casted) begin
          state_d = S_ACK;
          hold_d  = HOLD_RELOAD;
        end
      end
      S_ACK: begin
        if (mode) begin
          state_d = S_RESULT;
          hold_d  = '0;
`ifdef LEADER_DISPLAY_EN
          sel_d    = lead_idx;
          manual_d = 1'b0;
`endif
        end else if (valid_vote_casted) begin
          hold_d = HOLD_RELOAD;
        end else if (hold_cnt == '0) begin
          state_d = S_IDLE;
        end else begin
          hold_d = hold_cnt - 1'b1;
        end
      end
      S_RESULT: begin
        if (!mode) begin
          state_d = S_IDLE;
`ifdef LEADER_DISPLAY_EN
          manual_d = 1'b0;
`endif
        end else if (btn_any) begin
          sel_d = btn_idx;
`ifdef LEADER_DISPLAY_EN
          manual_d = 1'b1;
        end else if (!manual) begin
          sel_d = lead_idx;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Output is decoded from the next state so leds change on the same edge
    // as the state, and a new selection is shown as soon as it is latched.
    case (state_d)
      S_ACK:    leds_d = LED_W'(LED_ALL_ON);
      S_RESULT: leds_d = LED_W'(fit(FIT_W'(tally[sel_d]), LED_W));
      default:  leds_d = '0;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state    <= S_IDLE;
      hold_cnt <= '0;
      sel_idx  <= '0;
      leds     <= '0;
      ack_busy <= 1'b0;
`ifdef LEADER_DISPLAY_EN
      manual   <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      hold_cnt <= hold_d;
      sel_idx  <= sel_d;
      leds     <= leds_d;
      ack_busy <= (state_d == S_ACK);
`ifdef LEADER_DISPLAY_EN
      manual   <= manual_d;
`endif
    end
  end

endmodule

// File: tb/tb_vote_display_ctrl.sv
// Bench for vote_display_ctrl with NUM_CAND=4, VOTE_W=10, LED_W=8, HOLD_CYCLES=10.
// Directed table, hand-written reset sequence, then random traffic against a
// cycle-level behavioural model.
module tb_vote_display_ctrl;

  localparam int NC = 4;
  localparam int VW = 10;
  localparam int LW = 8;
  localparam int HC = 10;
`ifdef LEADER_DISPLAY_EN
  localparam bit LD = 1'b1;
`else
  localparam bit LD = 1'b0;
`endif

  logic                   clock = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   mode = 1'b0;
  logic                   vote = 1'b0;
  logic [NC-1:0][VW-1:0]  tal = '0;
  logic [NC-1:0]          btn = '0;
  logic [LW-1:0]          leds;
  logic                   ack_busy;
  logic [1:0]             sel_idx;

  always #5 clock = ~clock;

  vote_display_ctrl #(
    .NUM_CAND    (NC),
    .VOTE_W      (VW),
    .LED_W       (LW),
    .HOLD_CYCLES (HC)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .mode              (mode),
    .valid_vote_casted (vote),
    .cand_votes        (tal),
    .cand_button       (btn),
    .leds              (leds),
    .ack_busy          (ack_busy),
    .sel_idx           (sel_idx)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0; mode = 1'b0; vote = 1'b0; btn = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic                  m;
    logic                  v;
    logic [NC-1:0]         b;
    logic [NC-1:0][VW-1:0] t;
    int                    el;
    int                    eb;
    int                    es;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic m, input logic v, input logic [3:0] b,
                     input int t0, input int t1, input int t2, input int t3,
                     input int el, input int eb, input int es);
    vec_t e;
    e.m = m; e.v = v; e.b = b;
    e.t[0] = VW'(t0); e.t[1] = VW'(t1); e.t[2] = VW'(t2); e.t[3] = VW'(t3);
    e.el = el; e.eb = eb; e.es = es;
    tbl.push_back(e);
  endtask

  // ---------------- behavioural model ----------------
  int m_rem;    // acknowledge cycles still to be shown
  bit m_res;
  bit m_man;
  int m_sel;
  int m_leds;

  function automatic int fitm(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int argmax();
    int bi = 0;
    for (int i = 1; i < NC; i++) if (tal[i] > tal[bi]) bi = i;
    return bi;
  endfunction

  function automatic int lowbtn();
    for (int i = 0; i < NC; i++) if (btn[i]) return i;
    return 0;
  endfunction

  task automatic model_step();
    if (m_res) begin
      if (!mode) begin
        m_res = 1'b0; m_man = 1'b0;
      end else if (btn != '0) begin
        m_sel = lowbtn(); m_man = 1'b1;
      end else if (LD && !m_man) begin
        m_sel = argmax();
      end
    end else if (mode) begin
      m_res = 1'b1; m_rem = 0;
      if (LD) begin m_sel = argmax(); m_man = 1'b0; end
    end else if (vote) begin
      m_rem = HC;
    end else if (m_rem > 0) begin
      m_rem--;
    end
    m_leds = m_res ? fitm(int'(tal[m_sel])) : ((m_rem > 0) ? 255 : 0);
  endtask

  initial begin
    int s;
    // Build directed table: ack timing, retrigger, result select, saturation,
    // mode/vote priority, and ack -> result switch.
    add(0,1,4'b0000, 3,7,9,2, 8'hFF,1,0);
    for (int i = 0; i < 4; i++) add(0,0,4'b0000, 3,7,9,2, 8'hFF,1,0);
    add(0,1,4'b0000, 3,7,9,2, 8'hFF,1,0);
    for (int i = 0; i < 9; i++) add(0,0,4'b0000, 3,7,9,2, 8'hFF,1,0);
    add(0,0,4'b0000, 3,7,9,2, 8'h00,0,0);
    add(1,0,4'b0000, 3,7,9,2, LD ? 8'h09 : 8'h03, 0, LD ? 2 : 0);
    add(1,0,4'b0110, 3,7,9,2, 8'h07,0,1);
    add(1,0,4'b0000, 3,7,9,2, 8'h07,0,1);
    add(1,0,4'b0000, 3,300,9,2, 8'hFF,0,1);
    add(1,0,4'b0000, 3,200,9,2, 8'hC8,0,1);
    add(1,0,4'b1000, 3,200,9,2, 8'h02,0,3);
    add(0,0,4'b0000, 3,200,9,2, 8'h00,0,3);
    add(1,1,4'b0000, 3,200,9,2, LD ? 8'hC8 : 8'h02, 0, LD ? 1 : 3);
    add(1,1,4'b0000, 3,200,9,2, LD ? 8'hC8 : 8'h02, 0, LD ? 1 : 3);
    s = LD ? 1 : 3;
    add(0,0,4'b0000, 3,200,9,2, 8'h00,0,s);
    add(0,1,4'b0000, 3,200,9,2, 8'hFF,1,s);
    add(0,0,4'b0000, 3,200,9,2, 8'hFF,1,s);
    add(0,0,4'b0000, 3,200,9,2, 8'hFF,1,s);
    add(1,0,4'b0000, 3,200,9,2, LD ? 8'hC8 : 8'h02, 0, LD ? 1 : 3);
    add(0,0,4'b0000, 3,200,9,2, 8'h00,0,s);

    do_reset();
    check("reset_leds", leds, 0);
    check("reset_busy", ack_busy, 0);
    check("reset_sel", sel_idx, 0);

    foreach (tbl[k]) begin
      @(negedge clock);
      mode = tbl[k].m; vote = tbl[k].v; btn = tbl[k].b; tal = tbl[k].t;
      @(posedge clock); #1;
      check($sformatf("vec%0d_leds", k), leds, tbl[k].el);
      check($sformatf("vec%0d_busy", k), ack_busy, tbl[k].eb);
      check($sformatf("vec%0d_sel", k), sel_idx, tbl[k].es);
    end

    // Asynchronous reset in the middle of an acknowledge.
    @(negedge clock);
    mode = 1'b0; btn = '0; vote = 1'b1;
    @(negedge clock);
    vote = 1'b0;
    repeat (3) @(negedge clock);
    check("pre_rst_busy", ack_busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_leds", leds, 0);
    check("async_rst_busy", ack_busy, 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check("post_rst_leds", leds, 0);
    check("post_rst_busy", ack_busy, 0);
    vote = 1'b1;
    @(posedge clock); #1;
    check("post_rst_ack", leds, 8'hFF);
    @(negedge clock);
    vote = 1'b0;

    // Random traffic against the model.
    do_reset();
    m_rem = 0; m_res = 1'b0; m_man = 1'b0; m_sel = 0; m_leds = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      vote = ($urandom_range(0, 3) == 0);
      btn  = ($urandom_range(0, 5) == 0) ? NC'($urandom) : '0;
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < NC; i++)
          tal[i] = ($urandom_range(0, 4) == 0) ? VW'($urandom) : VW'($urandom_range(0, 12));
      @(posedge clock);
      model_step();
      #1;
      check("rnd_leds", leds, m_leds);
      check("rnd_busy", ack_busy, (!m_res && m_rem > 0) ? 1 : 0);
      check("rnd_sel", sel_idx, m_sel);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
